// File: rtl/alu_op_sequencer.sv
// Registered, back-pressurable wrapper around a combinational ALU: command in, result + flags out.
// Optional ALU_SEQ_CHAIN_EN adds cmd_chain_i to feed the last captured result back as operand A.
module alu_op_sequencer #(
  parameter int unsigned N = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cmd_valid_i,
  output logic         cmd_ready_o,
  input  logic [3:0]   cmd_sel_i,
  input  logic [N-1:0] cmd_a_i,
  input  logic [N-1:0] cmd_b_i,
`ifdef ALU_SEQ_CHAIN_EN
  input  logic         cmd_chain_i,
`endif
  output logic [N-1:0] alu_a_o,
  output logic [N-1:0] alu_b_o,
  output logic [3:0]   alu_sel_o,
  input  logic [N-1:0] alu_out_i,
  input  logic         alu_z_i,
  input  logic         alu_o_i,
  input  logic         alu_ca_i,
  input  logic         alu_neg_i,
  output logic         res_valid_o,
  input  logic         res_ready_i,
  output logic [N-1:0] res_data_o,
  output logic         res_z_o,
  output logic         res_o_o,
  output logic         res_ca_o,
  output logic         res_neg_o,
  output logic [7:0]   ops_done_o
);

  typedef enum logic [1:0] {StIdle, StExec, StHold} state_e;

  state_e       state_q;
  logic [N-1:0] alu_a_q, alu_b_q, res_data_q;
  logic [3:0]   alu_sel_q;
  logic         res_valid_q, res_z_q, res_o_q, res_ca_q, res_neg_q;
  logic [7:0]   ops_done_q;
  logic [N-1:0] a_src;

  // Only combinational input-to-output path: ready follows res_ready_i while holding a result.
  assign cmd_ready_o = (state_q == StIdle) || ((state_q == StHold) && res_ready_i);

`ifdef ALU_SEQ_CHAIN_EN
  assign a_src = cmd_chain_i ? res_data_q : cmd_a_i;
`else
  assign a_src = cmd_a_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      res_z_q     <= 1'b0;
      res_o_q     <= 1'b0;
      res_ca_q    <= 1'b0;
      res_neg_q   <= 1'b0;
      ops_done_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid_i) begin
            alu_a_q   <= a_src;
            alu_b_q   <= cmd_b_i;
            alu_sel_q <= cmd_sel_i;
            state_q   <= StExec;
          end
        end
        StExec: begin
          res_data_q  <= alu_out_i;
          res_z_q     <= alu_z_i;
          res_o_q     <= alu_o_i;
          res_ca_q    <= alu_ca_i;
          res_neg_q   <= alu_neg_i;
          res_valid_q <= 1'b1;
          state_q     <= StHold;
        end
        StHold: begin
          if (res_ready_i) begin
            ops_done_q  <= ops_done_q + 8'd1;
            res_valid_q <= 1'b0;
            if (cmd_valid_i) begin
              alu_a_q   <= a_src;
              alu_b_q   <= cmd_b_i;
              alu_sel_q <= cmd_sel_i;
              state_q   <= StExec;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_sel_o   = alu_sel_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_z_o     = res_z_q;
  assign res_o_o     = res_o_q;
  assign res_ca_o    = res_ca_q;
  assign res_neg_o   = res_neg_q;
  assign ops_done_o  = ops_done_q;

endmodule
